// File: rtl/driver_atuadores_pkg.sv
// Shared definitions between the alarm control FSM and the actuator driver:
// command bit positions, command codes and the pattern-phase encoding.
package alarme_pkg;

    localparam int unsigned IDX_LED   = 0;
    localparam int unsigned IDX_VIBRA = 1;
    localparam int unsigned IDX_APITA = 2;

    localparam logic [2:0] NULA             = 3'b000;
    localparam logic [2:0] LED0             = 3'b001;
    localparam logic [2:0] LED_VIBRA0       = 3'b011;
    localparam logic [2:0] LED_VIBRA_APITA0 = 3'b111;

    typedef enum logic {
        FASE_ON  = 1'b0,
        FASE_OFF = 1'b1
    } fase_t;

endpackage

// File: rtl/driver_atuadores_gerador_padrao.sv
// Periodic on/off pattern generator: while en is high the output is high for
// ON cycles, then low for OFF cycles, restarting at the ON phase on every enable.
module gerador_padrao
    import alarme_pkg::*;
#(
    parameter int unsigned ON    = 1,
    parameter int unsigned OFF   = 1,
    parameter int unsigned CNT_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic out
);

    localparam logic [CNT_W-1:0] ON_C     = CNT_W'(ON);
    localparam logic [CNT_W-1:0] OFF_C    = CNT_W'(OFF);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    fase_t            fase;

    // cnt == 0 only while idle, so it marks the first enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            fase <= FASE_ON;
            out  <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            fase <= FASE_ON;
            out  <= 1'b0;
        end else if (cnt == CNT_ZERO) begin
            cnt  <= CNT_ONE;
            fase <= FASE_ON;
            out  <= 1'b1;
        end else if (fase == FASE_ON) begin
            if (cnt == ON_C) begin
                cnt  <= CNT_ONE;
                fase <= FASE_OFF;
                out  <= 1'b0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end else begin
            if (cnt == OFF_C) begin
                cnt  <= CNT_ONE;
                fase <= FASE_ON;
                out  <= 1'b1;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/driver_atuadores.sv
// Actuator driver: turns the registered 3-bit alarm command into a blinking
// LED, a pulsed vibrator and a beeping square-wave tone on the speaker.
module driver_atuadores
    import alarme_pkg::*;
#(
    parameter int unsigned LED_HALF  = 25_000_000,
    parameter int unsigned VIB_ON    = 15_000_000,
    parameter int unsigned VIB_OFF   = 10_000_000,
    parameter int unsigned BEEP_ON   = 10_000_000,
    parameter int unsigned BEEP_OFF  = 5_000_000,
    parameter int unsigned TONE_HALF = 12_500,
    parameter int unsigned CNT_W     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] saida,
    output logic       led,
    output logic       vibra,
    output logic       speaker,
    output logic       busy
);

    logic [2:0] saida_q;
    logic       beep_q;
    logic       tone_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_q <= '0;
        end else begin
            saida_q <= saida;
        end
    end

    assign busy = |saida_q;

    gerador_padrao #(
        .ON    (LED_HALF),
        .OFF   (LED_HALF),
        .CNT_W (CNT_W)
    ) u_led (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (saida_q[IDX_LED]),
        .out   (led)
    );

    gerador_padrao #(
        .ON    (VIB_ON),
        .OFF   (VIB_OFF),
        .CNT_W (CNT_W)
    ) u_vibra (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (saida_q[IDX_VIBRA]),
        .out   (vibra)
    );

    gerador_padrao #(
        .ON    (BEEP_ON),
        .OFF   (BEEP_OFF),
        .CNT_W (CNT_W)
    ) u_beep (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (saida_q[IDX_APITA]),
        .out   (beep_q)
    );

    // Shares the speaker enable with the beep gate so both restart in step
    gerador_padrao #(
        .ON    (TONE_HALF),
        .OFF   (TONE_HALF),
        .CNT_W (CNT_W)
    ) u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (saida_q[IDX_APITA]),
        .out   (tone_q)
    );

    assign speaker = beep_q & tone_q;

endmodule

// File: tb/tb_driver_atuadores.sv
// Directed bench for driver_atuadores with short pattern lengths; expected
// waveforms are written as closed-form period formulas or explicit tables.
module tb_driver_atuadores;
    import alarme_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [2:0] saida;
    logic       led;
    logic       vibra;
    logic       speaker;
    logic       busy;

    int unsigned n_assert;
    int unsigned n_fail;

    driver_atuadores #(
        .LED_HALF  (4),
        .VIB_ON    (6),
        .VIB_OFF   (2),
        .BEEP_ON   (8),
        .BEEP_OFF  (4),
        .TONE_HALF (2),
        .CNT_W     (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .saida   (saida),
        .led     (led),
        .vibra   (vibra),
        .speaker (speaker),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between edges
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic pat(input int i, input int on_len, input int off_len);
        return ((i % (on_len + off_len)) < on_len) ? 1'b1 : 1'b0;
    endfunction

    initial begin
        logic exp_led;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        saida    = LED_VIBRA_APITA0;

        // Reset held with full command
        tick();
        tick();
        check("rst_led", led, 1'b0);
        check("rst_vibra", vibra, 1'b0);
        check("rst_speaker", speaker, 1'b0);
        check("rst_busy", busy, 1'b0);

        rst_n = 1'b1;
        tick();
        check("rel_busy", busy, 1'b1);
        check("rel_led_lat", led, 1'b0);
        tick();
        check("rel_led", led, 1'b1);
        check("rel_vibra", vibra, 1'b1);
        check("rel_speaker", speaker, 1'b1);

        // LED only
        pulse_reset();
        saida = LED0;
        tick();
        check("led_busy", busy, 1'b1);
        check("led_lat", led, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("led_only[%0d]", i), led, pat(i, 4, 4));
            check($sformatf("led_only_vib[%0d]", i), vibra, 1'b0);
            check($sformatf("led_only_spk[%0d]", i), speaker, 1'b0);
        end

        // LED + vibrator, then drop vibrator mid-pattern
        pulse_reset();
        saida = LED_VIBRA0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) saida = LED0;
            tick();
            check($sformatf("lv_led[%0d]", i), led, pat(i, 4, 4));
            check($sformatf("lv_vib[%0d]", i), vibra, (i <= 10) ? pat(i, 6, 2) : 1'b0);
        end

        // Full command: gated tone
        pulse_reset();
        saida = LED_VIBRA_APITA0;
        tick();
        for (int i = 0; i < 24; i++) begin
            tick();
            check($sformatf("spk[%0d]", i), speaker, pat(i, 8, 4) & pat(i, 2, 2));
            check($sformatf("spk_vib[%0d]", i), vibra, pat(i, 6, 2));
        end

        // Speaker-only non-canonical code
        pulse_reset();
        saida = 3'b100;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("apita_spk[%0d]", i), speaker, pat(i, 8, 4) & pat(i, 2, 2));
            check($sformatf("apita_led[%0d]", i), led, 1'b0);
        end

        // One-cycle drop of the LED bit during an on-phase
        pulse_reset();
        saida = LED0;
        tick();
        for (int i = 0; i < 8; i++) tick();
        for (int j = 0; j < 11; j++) begin
            if (j == 1) saida = NULA;
            if (j == 2) saida = LED0;
            tick();
            if (j < 2)       exp_led = 1'b1;
            else if (j == 2) exp_led = 1'b0;
            else if (j < 7)  exp_led = 1'b1;
            else             exp_led = 1'b0;
            check($sformatf("glitch_led[%0d]", j), led, exp_led);
            if (j == 1) check("glitch_busy_lo", busy, 1'b0);
            if (j == 2) check("glitch_busy_hi", busy, 1'b1);
        end

        // Asynchronous reset between edges mid-pattern
        pulse_reset();
        saida = LED_VIBRA_APITA0;
        tick();
        tick();
        tick();
        check("async_pre_led", led, 1'b1);
        rst_n = 1'b0;
        #2;
        check("async_led", led, 1'b0);
        check("async_vibra", vibra, 1'b0);
        check("async_speaker", speaker, 1'b0);
        check("async_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();
        check("async_rel_busy", busy, 1'b1);
        check("async_rel_led_lat", led, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("async_led[%0d]", i), led, pat(i, 4, 4));
            check($sformatf("async_spk[%0d]", i), speaker, pat(i, 8, 4) & pat(i, 2, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
